// File: rtl/bsr_pkg.sv
// rtl/bsr_pkg.sv - shared types and constants for the bsr register and its feeder
package bsr_pkg;

    localparam int   BSR_WIDTH = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/bsr.sv
// rtl/bsr.sv - bidirectional shift register with serial right/left inputs
module bsr
    import bsr_pkg::*;
#(
    parameter int WIDTH = BSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ri,
    input  logic             li,
    input  logic             rl_mode,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Right shift brings ri in at the MSB; left shift brings li in at the LSB.
    always_comb begin
        if (rl_mode == DIR_RIGHT) begin
            q_d = {ri, q_q[WIDTH-1:1]};
        end else begin
            q_d = {q_q[WIDTH-2:0], li};
        end
    end

    // Register update with active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bsr_feeder_fsm.sv
// rtl/bsr_feeder_fsm.sv - feeder sequencing: state register, bit counter, handshake decode
module bsr_feeder_fsm
    import bsr_pkg::*;
#(
    parameter int WIDTH = BSR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  accept,
    output logic                  word_valid,
    output feeder_state_e         state_q,
    output feeder_state_e         state_d,
    output logic [$clog2(WIDTH):0] cnt_q
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_d;

    // A word can be taken while idle or in the check cycle (back-to-back).
    assign in_ready   = rst && (state_q == ST_IDLE || state_q == ST_CHECK);
    assign accept     = in_valid && in_ready;
    assign word_valid = (state_q == ST_CHECK);

    // Next-state and bit-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/bsr_feeder.sv
// rtl/bsr_feeder.sv - serializes a parallel word into bsr and verifies the readback
module bsr_feeder
    import bsr_pkg::*;
#(
    parameter int WIDTH = BSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q,
    output logic             ri,
    output logic             li,
    output logic             rl_mode,
    output logic             busy,
    output logic             word_valid,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = $clog2(WIDTH);

    feeder_state_e    state_q;
    feeder_state_e    state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic             ri_q, ri_d;
    logic             li_q, li_d;
    logic             rl_mode_q, rl_mode_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             send;
    logic [WIDTH-1:0] src_data;
    logic             src_dir;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos;
    logic             bit_val;

    bsr_feeder_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .accept     (accept),
        .word_valid (word_valid),
        .state_q    (state_q),
        .state_d    (state_d),
        .cnt_q      (cnt_q)
    );

    // Latch the word, pick the next serial bit, and accumulate readback mismatches.
    always_comb begin
        data_d    = data_q;
        dir_d     = dir_q;
        rl_mode_d = rl_mode_q;
        err_d     = err_q;
        src_data  = data_q;
        src_dir   = dir_q;
        send      = 1'b0;
        idx       = '0;

        if (accept) begin
            // The first bit comes straight from the input since the latch fills on this edge.
            data_d    = in_data;
            dir_d     = in_dir;
            rl_mode_d = in_dir;
            src_data  = in_data;
            src_dir   = in_dir;
            send      = 1'b1;
        end else if (state_q == ST_SHIFT && state_d == ST_SHIFT) begin
            send = 1'b1;
            idx  = IDX_W'(cnt_q + CNT_W'(1));
        end

        // Left shifts enter at q[0], so the MSB must go first to end up at the top.
        pos     = (src_dir == DIR_LEFT) ? (IDX_W'(WIDTH - 1) - idx) : idx;
        bit_val = send & src_data[pos];
        ri_d    = (src_dir == DIR_RIGHT) & bit_val;
        li_d    = (src_dir == DIR_LEFT) & bit_val;

        if (state_q == ST_CHECK && q != data_q) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Output and latch registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q    <= '0;
            dir_q     <= 1'b0;
            ri_q      <= 1'b0;
            li_q      <= 1'b0;
            rl_mode_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            dir_q     <= dir_d;
            ri_q      <= ri_d;
            li_q      <= li_d;
            rl_mode_q <= rl_mode_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ri      = ri_q;
    assign li      = li_q;
    assign rl_mode = rl_mode_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: doc/bsr_feeder.md
# bsr_feeder

Serializing front end for the 4-bit bidirectional shift register (`bsr`). Accepts a parallel word and a shift direction over a valid/ready handshake, then drives `ri`/`li` and `rl_mode` one bit per clock so that `bsr` holds the word after WIDTH shifts. In the check cycle it reads back `bsr.q` and records any mismatch. One word per transaction, no buffering beyond the captured word.

## Interface
- `WIDTH`, 4: word width; must equal the `bsr` register width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  WIDTH  word to load into `bsr`.
- `in_dir`  in  1  0 = right shift (serial input on `ri`), 1 = left shift (serial input on `li`).
- `in_ready`  out  1  feeder can accept a word this cycle.
- `q`  in  WIDTH  readback of `bsr.q`.
- `ri`  out  1  right serial input to `bsr`.
- `li`  out  1  left serial input to `bsr`.
- `rl_mode`  out  1  direction to `bsr`; equals the latched `in_dir`.
- `busy`  out  1  transaction in progress (SHIFT or CHECK).
- `word_valid`  out  1  high for exactly one cycle (CHECK) when `bsr` should hold the word.
- `err`  out  1  sticky mismatch flag.

## Operation
- States: IDLE, SHIFT, CHECK.
- Handshake: the feeder accepts a word on an edge where `rst`=1, `in_valid`=1 and `in_ready`=1. `in_ready` = `rst` & (state is IDLE or CHECK). It is combinational from registered state.
- On acceptance: latch `in_data` into `data_q` and `in_dir` into `dir_q`. Clear bit counter `cnt`. Drive the first bit. Go to SHIFT.
- Bit order:
  - dir 0 (bit enters at q[WIDTH-1], moves toward q[0]): send `data_q[0]` first, then ascending.
  - dir 1 (bit enters at q[0]): send `data_q[WIDTH-1]` first, then descending.
- The active serial line carries the bit. The inactive line is held at 0. `rl_mode` holds `dir_q` for the whole transaction and keeps its last value in IDLE.
- SHIFT: `cnt` increments each edge. After WIDTH bits have been presented, go to CHECK. `cnt` is `$clog2(WIDTH)+1` bits and never wraps inside a transaction.
- CHECK: `word_valid`=1. Compare `q` with `data_q`.
  - On the CHECK-exit edge, `err` is set if they differ.
  - If a handshake occurs on that edge, go directly to SHIFT (back-to-back). Otherwise go to IDLE.
- `in_valid`/`in_data`/`in_dir` changes during SHIFT are ignored. `in_ready`=0 in SHIFT.
- `err` clears only on reset.
- Reset (`rst`=0 at an edge, any state, including mid-SHIFT):
  - State returns to IDLE.
  - `ri`=`li`=`rl_mode`=0, `busy`=0, `word_valid`=0, `err`=0, `cnt`=0.
  - No partial word is completed or flagged.

## Timing
- E0 = acceptance edge. Bit k is valid on the serial line from E(k) to E(k+1), and `bsr` samples it at E(k+1).
- The last bit is sampled at E(WIDTH). CHECK spans E(WIDTH)..E(WIDTH+1). `q` is compared in that cycle. `err` is visible after E(WIDTH+1).
- Latency from acceptance to `word_valid`: WIDTH cycles. Throughput with back-to-back: one word per WIDTH+1 cycles.
- `ri`, `li`, `rl_mode`, `busy`, `err` are registered. `word_valid` and `in_ready` are decoded from the state register.

## Structure
- Shared package `bsr_pkg`:
  - state enum (IDLE/SHIFT/CHECK)
  - direction constants `DIR_RIGHT`=0, `DIR_LEFT`=1
  - default width constant `BSR_WIDTH`=4
- Natural sub-module: `bsr_feeder_fsm` (state register, `cnt`, handshake decode). The top holds the data/direction latches, the bit mux, output registers and the comparator.
- Bench instantiates `bsr_feeder` driving a real `bsr`. Note that `bsr` reset is active-high, so drive it with the inverse of the feeder's `rst`.

## Test plan
- `in_data`=4'b1011, `in_dir`=0 → `ri` = 1,1,0,1 on E0..E3; `li`=0; `rl_mode`=0; `word_valid` in cycle E4..E5; `q`=1011; `err`=0.
- `in_data`=4'b0110, `in_dir`=1 → `li` = 0,1,1,0; `ri`=0; `rl_mode`=1; `q`=0110 at CHECK; `err`=0.
- Back-to-back 4'b1100 (dir 0) then 4'b0011 (dir 1), `in_valid` held high → second accept on the first word's CHECK-exit edge; `word_valid` pulses 5 cycles apart; `err`=0.
- Bench forces `q`=4'b0000 during CHECK of word 4'b1111 → `err`=1 after the CHECK-exit edge. `err` stays 1 through later correct words until `rst`=0.
- `rst`=0 at E2 of a transaction → next cycle state is IDLE; all outputs 0; no `word_valid`. After `rst`=1, `in_ready`=1 and a new word completes normally.
- `in_valid` toggling with new data during SHIFT → ignored; the shifted bits match the originally latched word.
